// File: rtl/hdlc_rx_ctrl.sv
// HDLC receive frame sequencer: frame start/end, buffer writes,
// FCS start/stop strobes and held-frame status toward the CPU.
module hdlc_rx_ctrl #(
  parameter int MAX_BYTES = 128,
  parameter int FCS_BYTES = 2,
  parameter int FCS_LAT   = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxEN,
  input  logic       Rx_FlagDetect,
  input  logic       Rx_AbortDetect,
  input  logic       Rx_NewByte,
  input  logic       Rx_FCSen,
  input  logic       Rx_FCSerr,
  input  logic       Rx_Drop,
  input  logic       Rx_RdBuff,
  output logic       Rx_WrBuff,
  output logic [7:0] Rx_WrAddr,
  output logic       Rx_ValidFrame,
  output logic       Rx_StartZeroDetect,
  output logic       Rx_StartFCS,
  output logic       Rx_StopFCS,
  output logic       Rx_EoF,
  output logic       Rx_Ready,
  output logic [7:0] Rx_FrameSize,
  output logic       Rx_Overflow,
  output logic       Rx_FrameError,
  output logic       Rx_AbortSignal
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HUNT  = 3'd1;
  localparam logic [2:0] S_FRAME = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_READY = 3'd4;

  localparam int LW = $clog2(FCS_LAT + 1);
  localparam logic [LW-1:0] LAT  = LW'(FCS_LAT);
  localparam logic [7:0]    MAXB = 8'(MAX_BYTES);
  localparam logic [7:0]    FCSB = 8'(FCS_BYTES);

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    rd_q, rd_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          ready_q, ready_d;
  logic [7:0]    size_q, size_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;
  logic          abrt_q, abrt_d;

  logic in_frame;
  logic full;
  logic eof;
  logic short_frm;

  assign in_frame  = (state_q == S_FRAME) && RxEN;
  assign full      = (cnt_q == MAXB);
  assign eof       = (state_q == S_CHECK) && RxEN && (lat_q == LAT);
  assign short_frm = Rx_FCSen && (cnt_q <= FCSB);

  // Abort outranks flag, and flag outranks a coincident byte.
  assign Rx_WrBuff = in_frame && Rx_NewByte && !Rx_FlagDetect
                   && !Rx_AbortDetect && !full;

  assign Rx_WrAddr          = cnt_q;
  assign Rx_ValidFrame      = (state_q == S_FRAME);
  assign Rx_StartZeroDetect = (state_q == S_FRAME);
  assign Rx_StartFCS        = start_q;
  assign Rx_StopFCS         = stop_q;
  assign Rx_EoF             = eof;
  assign Rx_Ready           = ready_q;
  assign Rx_FrameSize       = size_q;
  assign Rx_Overflow        = ovf_q;
  assign Rx_FrameError      = ferr_q;
  assign Rx_AbortSignal     = abrt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    lat_d   = lat_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    ready_d = ready_q;
    size_d  = size_q;
    ovf_d   = ovf_q;
    ferr_d  = ferr_q;
    abrt_d  = abrt_q;
    case (state_q)
      S_IDLE: begin
        if (RxEN) state_d = S_HUNT;
      end
      S_HUNT: begin
        if (!RxEN) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (Rx_FlagDetect) begin
          state_d = S_FRAME;
          start_d = 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          ferr_d  = 1'b0;
          abrt_d  = 1'b0;
        end
      end
      S_FRAME: begin
        if (!RxEN) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (Rx_AbortDetect) begin
          state_d = S_HUNT;
          if (cnt_q != '0) abrt_d = 1'b1;
        end else if (Rx_FlagDetect) begin
          if (cnt_q == '0) begin
            start_d = 1'b1;
          end else begin
            stop_d  = 1'b1;
            state_d = S_CHECK;
            lat_d   = '0;
          end
        end else if (Rx_NewByte) begin
          if (full) ovf_d = 1'b1;
          else      cnt_d = cnt_q + 8'd1;
        end
      end
      S_CHECK: begin
        if (!RxEN) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (lat_q == LAT) begin
          // A failed frame's closing flag opens the next frame.
          if (short_frm || (!ovf_q && Rx_FCSen && Rx_FCSerr)) begin
            ferr_d  = 1'b1;
            state_d = S_FRAME;
            start_d = 1'b1;
            cnt_d   = '0;
          end else begin
            ready_d = 1'b1;
            rd_d    = '0;
            state_d = S_READY;
            if (ovf_q)         size_d = MAXB;
            else if (Rx_FCSen) size_d = cnt_q - FCSB;
            else               size_d = cnt_q;
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_READY: begin
        if (Rx_Drop || (Rx_RdBuff && (rd_q + 8'd1 == size_q))) begin
          ready_d = 1'b0;
          rd_d    = '0;
          state_d = S_HUNT;
        end else if (Rx_RdBuff) begin
          rd_d = rd_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      lat_q   <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      ready_q <= 1'b0;
      size_q  <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      lat_q   <= lat_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      ready_q <= ready_d;
      size_q  <= size_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
      abrt_q  <= abrt_d;
    end
  end

endmodule

// File: tb/tb_hdlc_rx_ctrl.sv
// Directed vector bench for hdlc_rx_ctrl: per-cycle table plus
// hand sequences for overflow, drop and mid-frame reset.
module tb_hdlc_rx_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       RxEN;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_NewByte;
  logic       Rx_FCSen;
  logic       Rx_FCSerr;
  logic       Rx_Drop;
  logic       Rx_RdBuff;
  logic       Rx_WrBuff;
  logic [7:0] Rx_WrAddr;
  logic       Rx_ValidFrame;
  logic       Rx_StartZeroDetect;
  logic       Rx_StartFCS;
  logic       Rx_StopFCS;
  logic       Rx_EoF;
  logic       Rx_Ready;
  logic [7:0] Rx_FrameSize;
  logic       Rx_Overflow;
  logic       Rx_FrameError;
  logic       Rx_AbortSignal;

  hdlc_rx_ctrl #(.MAX_BYTES(128), .FCS_BYTES(2), .FCS_LAT(2)) dut (
    .Clk(Clk), .Rst(Rst), .RxEN(RxEN),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_NewByte(Rx_NewByte), .Rx_FCSen(Rx_FCSen), .Rx_FCSerr(Rx_FCSerr),
    .Rx_Drop(Rx_Drop), .Rx_RdBuff(Rx_RdBuff),
    .Rx_WrBuff(Rx_WrBuff), .Rx_WrAddr(Rx_WrAddr),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_StartZeroDetect(Rx_StartZeroDetect),
    .Rx_StartFCS(Rx_StartFCS), .Rx_StopFCS(Rx_StopFCS), .Rx_EoF(Rx_EoF),
    .Rx_Ready(Rx_Ready), .Rx_FrameSize(Rx_FrameSize),
    .Rx_Overflow(Rx_Overflow), .Rx_FrameError(Rx_FrameError),
    .Rx_AbortSignal(Rx_AbortSignal)
  );

  always #5 Clk = ~Clk;

  // in  = {rxen,flag,abort,newbyte,fcserr,rdbuff,drop}
  // exp = {wr,valid,start,stop,eof,ready,ovf,ferr,abort}
  typedef struct {
    logic [6:0] in;
    logic [8:0] exp;
    logic [7:0] addr;
    logic [7:0] size;
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void v(input logic [6:0] i, input logic [8:0] e,
                            input int a, input int s);
    vec_t t;
    t.in   = i;
    t.exp  = e;
    t.addr = 8'(a);
    t.size = 8'(s);
    tv.push_back(t);
  endfunction

  function automatic logic [8:0] outs();
    return {Rx_WrBuff, Rx_ValidFrame, Rx_StartFCS, Rx_StopFCS, Rx_EoF,
            Rx_Ready, Rx_Overflow, Rx_FrameError, Rx_AbortSignal};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int nwr;
    int wait_n;
    Rst = 1'b1; RxEN = 0; Rx_FlagDetect = 0; Rx_AbortDetect = 0;
    Rx_NewByte = 0; Rx_FCSen = 1; Rx_FCSerr = 0; Rx_Drop = 0;
    Rx_RdBuff = 0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    // reset state, then RxEN drop mid-frame
    v(7'b0000000, 9'b000000000, 0, 0);
    v(7'b1000000, 9'b000000000, 0, 0);
    v(7'b1100000, 9'b000000000, 0, 0);
    v(7'b1001000, 9'b111000000, 0, 0);
    v(7'b1001000, 9'b110000000, 1, 0);
    v(7'b1001000, 9'b110000000, 2, 0);
    v(7'b1001000, 9'b110000000, 3, 0);
    v(7'b0001000, 9'b010000000, 4, 0);
    v(7'b0000000, 9'b000000000, 0, 0);
    v(7'b1000000, 9'b000000000, 0, 0);
    v(7'b1000000, 9'b000000000, 0, 0);
    // good 5-byte frame, FCS stripped, read out
    v(7'b1100000, 9'b000000000, 0, 0);
    v(7'b1001000, 9'b111000000, 0, 0);
    v(7'b1001000, 9'b110000000, 1, 0);
    v(7'b1001000, 9'b110000000, 2, 0);
    v(7'b1001000, 9'b110000000, 3, 0);
    v(7'b1001000, 9'b110000000, 4, 0);
    v(7'b1100000, 9'b010000000, 5, 0);
    v(7'b1000000, 9'b000100000, 5, 0);
    v(7'b1000000, 9'b000000000, 5, 0);
    v(7'b1000000, 9'b000010000, 5, 0);
    v(7'b1000010, 9'b000001000, 5, 3);
    v(7'b1101000, 9'b000001000, 5, 3);
    v(7'b1000010, 9'b000001000, 5, 3);
    v(7'b1000010, 9'b000001000, 5, 3);
    v(7'b1000001, 9'b000000000, 5, 3);
    // bad FCS, next frame rides on the closing flag
    v(7'b1100000, 9'b000000000, 5, 3);
    v(7'b1001000, 9'b111000000, 0, 3);
    v(7'b1001000, 9'b110000000, 1, 3);
    v(7'b1001000, 9'b110000000, 2, 3);
    v(7'b1001000, 9'b110000000, 3, 3);
    v(7'b1001000, 9'b110000000, 4, 3);
    v(7'b1100100, 9'b010000000, 5, 3);
    v(7'b1000100, 9'b000100000, 5, 3);
    v(7'b1000100, 9'b000000000, 5, 3);
    v(7'b1000100, 9'b000010000, 5, 3);
    v(7'b1001000, 9'b111000010, 0, 3);
    v(7'b1001000, 9'b110000010, 1, 3);
    v(7'b1001000, 9'b110000010, 2, 3);
    // abort together with flag after 3 bytes
    v(7'b1110000, 9'b010000010, 3, 3);
    v(7'b1000000, 9'b000000011, 3, 3);
    v(7'b1100000, 9'b000000011, 3, 3);
    v(7'b1000000, 9'b011000000, 0, 3);
    // idle flags, then short frame
    v(7'b1100000, 9'b010000000, 0, 3);
    v(7'b1100000, 9'b011000000, 0, 3);
    v(7'b1000000, 9'b011000000, 0, 3);
    v(7'b1001000, 9'b110000000, 0, 3);
    v(7'b1001000, 9'b110000000, 1, 3);
    v(7'b1100000, 9'b010000000, 2, 3);
    v(7'b1000000, 9'b000100000, 2, 3);
    v(7'b1000000, 9'b000000000, 2, 3);
    v(7'b1000000, 9'b000010000, 2, 3);
    v(7'b1000000, 9'b011000010, 0, 3);
    // flag beats byte; abort at count 0 is silent
    v(7'b1101000, 9'b010000010, 0, 3);
    v(7'b1000000, 9'b011000010, 0, 3);
    v(7'b1010000, 9'b010000010, 0, 3);
    v(7'b1000000, 9'b000000010, 0, 3);

    foreach (tv[k]) begin
      {RxEN, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_FCSerr,
       Rx_RdBuff, Rx_Drop} = tv[k].in;
      @(negedge Clk);
      chk($sformatf("row%0d", k), {40'd0, outs(), Rx_WrAddr, Rx_FrameSize},
          {40'd0, tv[k].exp, tv[k].addr, tv[k].size});
      chk($sformatf("row%0d_zd", k), 64'(Rx_StartZeroDetect),
          64'(tv[k].exp[7]));
      cyc();
    end

    // overflow: 130 bytes into a 128-byte buffer
    {RxEN, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_FCSerr,
     Rx_RdBuff, Rx_Drop} = 7'b1100000;
    cyc();
    Rx_FlagDetect = 0;
    nwr = 0;
    for (int i = 0; i < 130; i++) begin
      Rx_NewByte = 1;
      @(negedge Clk);
      if (Rx_WrBuff) nwr++;
      cyc();
    end
    Rx_NewByte = 0;
    @(negedge Clk);
    chk("ovf_writes", 64'(nwr), 64'd128);
    chk("ovf_flag", 64'(Rx_Overflow), 64'd1);
    chk("ovf_addr", 64'(Rx_WrAddr), 64'd128);
    cyc();
    Rx_FlagDetect = 1;
    cyc();
    Rx_FlagDetect = 0;
    wait_n = 0;
    @(negedge Clk);
    while (!Rx_EoF && wait_n < 8) begin
      wait_n++;
      @(negedge Clk);
    end
    chk("ovf_eof_seen", 64'(Rx_EoF), 64'd1);
    @(negedge Clk);
    chk("ovf_status", {61'd0, Rx_Ready, Rx_Overflow, Rx_FrameError},
        64'b110);
    chk("ovf_size", 64'(Rx_FrameSize), 64'd128);
    cyc();
    // drop the held frame
    Rx_Drop = 1;
    @(negedge Clk);
    chk("drop_same", 64'(Rx_Ready), 64'd1);
    cyc();
    Rx_Drop = 0;
    @(negedge Clk);
    chk("drop_next", 64'(Rx_Ready), 64'd0);
    cyc();
    Rx_FlagDetect = 1;
    cyc();
    Rx_FlagDetect = 0;
    @(negedge Clk);
    chk("hunt_after_drop", {62'd0, Rx_ValidFrame, Rx_StartFCS}, 64'b11);
    // reset mid-frame after 4 bytes
    for (int i = 0; i < 4; i++) begin
      Rx_NewByte = 1;
      cyc();
    end
    Rst = 1;
    cyc();
    Rst = 0;
    Rx_NewByte = 0;
    @(negedge Clk);
    chk("rst_mid_outs", {39'd0, outs(), Rx_StartZeroDetect, Rx_WrAddr,
        Rx_FrameSize}, 64'd0);
    cyc();
    Rx_FlagDetect = 1;
    @(negedge Clk);
    chk("rst_idle", {62'd0, Rx_ValidFrame, Rx_EoF}, 64'd0);
    cyc();
    Rx_FlagDetect = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_ctrl.md
Name: hdlc_rx_ctrl

Overview:
Frame-level sequencer for the HDLC receive path. Consumes flag, abort and byte strobes from the Rx bit-level front end (flag/abort detector, zero-removal shifter) and decides frame start and end. Drives buffer writes, FCS start and stop, and frame status (valid, ready, error, overflow, abort) toward the Rx buffer and the CPU register interface. Holds a completed frame until the CPU reads it or drops it.

Parameters:
MAX_BYTES, 128, Rx buffer depth in bytes (2..255), including the FCS bytes.
FCS_BYTES, 2, number of trailing FCS bytes stripped from Rx_FrameSize when Rx_FCSen=1.
FCS_LAT, 2, cycles from the Rx_StopFCS pulse until Rx_FCSerr is valid (>=1).

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
RxEN  in  1  receiver enable (level)
Rx_FlagDetect  in  1  1-cycle pulse: 01111110 seen
Rx_AbortDetect  in  1  1-cycle pulse: 7+ consecutive ones seen
Rx_NewByte  in  1  1-cycle pulse: destuffed byte valid on Rx_Data
Rx_FCSen  in  1  FCS checking enabled (level, CPU register)
Rx_FCSerr  in  1  FCS checker result, sampled FCS_LAT cycles after Rx_StopFCS
Rx_Drop  in  1  1-cycle pulse from CPU: discard held frame
Rx_RdBuff  in  1  1-cycle pulse per CPU byte read from the buffer
Rx_WrBuff  out  1  buffer write strobe; buffer captures Rx_Data at Rx_WrAddr
Rx_WrAddr  out  8  buffer write address (current byte count)
Rx_ValidFrame  out  1  frame in progress
Rx_StartZeroDetect  out  1  enable for the zero-removal logic
Rx_StartFCS  out  1  1-cycle pulse: clear/start FCS accumulator
Rx_StopFCS  out  1  1-cycle pulse: close FCS accumulation
Rx_EoF  out  1  1-cycle pulse: frame ended (good or bad)
Rx_Ready  out  1  good frame held in buffer
Rx_FrameSize  out  8  payload bytes of held frame
Rx_Overflow  out  1  sticky: held frame exceeded MAX_BYTES
Rx_FrameError  out  1  sticky: last frame had bad FCS or was too short
Rx_AbortSignal  out  1  sticky: last frame aborted

Behaviour:
- Reset (Rst=1 at a Clk edge): state IDLE, byte count=0, read count=0. Every output is 0, including Rx_FrameSize and Rx_WrAddr. Reset mid-frame discards the frame with no Rx_EoF.
- States: IDLE, HUNT, FRAME, CHECK, READY.
- IDLE: if RxEN=1, go to HUNT.
- RxEN=0 in HUNT, FRAME or CHECK: go to IDLE next cycle, frame discarded, no status change. READY ignores RxEN.
- HUNT: on Rx_FlagDetect, go to FRAME, pulse Rx_StartFCS, count=0, clear Rx_FrameError, Rx_AbortSignal and Rx_Overflow.
- FRAME: Rx_ValidFrame=1 and Rx_StartZeroDetect=1; both are 0 in every other state.
- Rx_NewByte with count<MAX_BYTES: Rx_WrBuff=1 in the same cycle (combinational), Rx_WrAddr=count, then count+1.
- Rx_NewByte with count=MAX_BYTES: no write, Rx_Overflow=1, count saturates.
- Rx_FlagDetect with count=0 (shared or idle flags): re-pulse Rx_StartFCS, stay in FRAME.
- Rx_FlagDetect with count>0: pulse Rx_StopFCS, go to CHECK.
- Rx_AbortDetect with count>0: Rx_AbortSignal=1, go to HUNT, no Rx_EoF.
- Rx_AbortDetect with count=0: go to HUNT silently.
- Simultaneous flag and abort: abort wins. Simultaneous flag and byte: flag wins, byte dropped.
- CHECK: wait FCS_LAT cycles, then pulse Rx_EoF. Classify the frame:
  - Short frame (Rx_FCSen=1 and count<=FCS_BYTES): Rx_FrameError=1.
  - Overflow: Rx_Ready=1, Rx_FrameSize=MAX_BYTES, FCS result ignored.
  - Rx_FCSen=1 and Rx_FCSerr=1: Rx_FrameError=1.
  - Otherwise good: Rx_Ready=1, Rx_FrameSize=count-FCS_BYTES if Rx_FCSen else count.
- After CHECK: if Rx_Ready=1 go to READY, else go to FRAME with an Rx_StartFCS pulse (the closing flag opens the next frame). Incoming events during CHECK are ignored.
- READY: all incoming Rx events are ignored and there are no writes.
- Each Rx_RdBuff increments the read count. When the read count reaches Rx_FrameSize, or on Rx_Drop, the next cycle gives Rx_Ready=0, read count=0, and the state goes to HUNT.
- Rx_FrameSize holds its value until the next Rx_Ready assertion.
- Rx_Drop outside READY has no effect.

Test Plan:
1. Rx_FCSen=1; flag, 5 bytes (0x11..0x15), flag, Rx_FCSerr=0 -> 5 Rx_WrBuff pulses at addr 0..4; Rx_StopFCS 1 cycle after the closing flag; Rx_EoF 2 cycles later; Rx_Ready=1, Rx_FrameSize=3. Then 3 Rx_RdBuff pulses -> Rx_Ready=0, state HUNT.
2. Same frame with Rx_FCSerr=1 -> Rx_EoF pulse, Rx_FrameError=1, Rx_Ready=0; next flag+bytes are accepted with no second opening flag needed.
3. Flag, 3 bytes, Rx_AbortDetect -> Rx_AbortSignal=1, no Rx_EoF, Rx_Ready=0. A new flag clears Rx_AbortSignal and pulses Rx_StartFCS.
4. Flag, 130 bytes with MAX_BYTES=128, flag -> exactly 128 writes, Rx_Overflow=1, Rx_Ready=1, Rx_FrameSize=128.
5. Rx_FCSen=1; flag, 2 bytes, flag -> Rx_FrameError=1, Rx_Ready=0. Back-to-back flags (count=0) -> no Rx_EoF, only Rx_StartFCS pulses.
6. Rst=1 mid-frame after 4 bytes, and RxEN=0 mid-frame -> all outputs 0 and state IDLE next cycle; Rx_Drop in READY -> Rx_Ready=0 next cycle.
